// File: rtl/load_store_unit.sv
// Load/store unit: sized, sign/zero-extended loads and byte/half/word stores against a word-wide data memory.
// Latency: loads and word stores respond 2 cycles after req, sub-word stores 3 cycles, illegal requests 1 cycle.
// Backpressure: one access at a time; req is sampled only in IDLE and ignored (not queued) while busy.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] adr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] memAdr,
  output logic [31:0] memWriteData,
  output logic        memWrite,
  input  logic [31:0] memReadData
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    MERGE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Request fields captured on the edge that leaves IDLE.
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] adr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] merge_q;

  logic [1:0]  size_in;
  logic [1:0]  size_q;
  logic        illegal;
  logic        accept;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merge_val;

  assign size_in = funct3[1:0];
  assign size_q  = f3_q[1:0];
  assign accept  = (state == IDLE) && req;

  // Classify the incoming request: reserved size codes and misaligned addresses go straight to RESP.
  always_comb begin
    illegal = 1'b0;
    if (size_in == 2'b11)
      illegal = 1'b1;
    if (!we && (funct3 == 3'b110))
      illegal = 1'b1;
    if ((size_in == 2'b10) && (adr[1:0] != 2'b00))
      illegal = 1'b1;
    if ((size_in == 2'b01) && adr[0])
      illegal = 1'b1;
  end

  // Next-state logic; only sub-word stores need the extra MERGE cycle for read-modify-write.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req) state_nxt = illegal ? RESP : ACCESS;
      ACCESS:  state_nxt = (we_q && (size_q != 2'b10)) ? MERGE : RESP;
      MERGE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pick the addressed little-endian lanes out of the memory word and extend them.
  always_comb begin
    lane_b = memReadData[7:0];
    case (adr_q[1:0])
      2'b00: lane_b = memReadData[7:0];
      2'b01: lane_b = memReadData[15:8];
      2'b10: lane_b = memReadData[23:16];
      2'b11: lane_b = memReadData[31:24];
      default: lane_b = memReadData[7:0];
    endcase
    lane_h = adr_q[1] ? memReadData[31:16] : memReadData[15:0];
    case (size_q)
      2'b00:   load_val = {{24{~f3_q[2] & lane_b[7]}}, lane_b};
      2'b01:   load_val = {{16{~f3_q[2] & lane_h[15]}}, lane_h};
      default: load_val = memReadData;
    endcase
  end

  // Overlay the store data onto the current memory word; untouched lanes keep memory contents.
  always_comb begin
    merge_val = memReadData;
    if (size_q == 2'b00) begin
      case (adr_q[1:0])
        2'b00: merge_val[7:0]   = wdata_q[7:0];
        2'b01: merge_val[15:8]  = wdata_q[7:0];
        2'b10: merge_val[23:16] = wdata_q[7:0];
        2'b11: merge_val[31:24] = wdata_q[7:0];
        default: merge_val = memReadData;
      endcase
    end else if (adr_q[1]) begin
      merge_val[31:16] = wdata_q[15:0];
    end else begin
      merge_val[15:0] = wdata_q[15:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Latch the request fields when a request is accepted in IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      adr_q   <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= we;
      f3_q    <= funct3;
      adr_q   <= adr;
      wdata_q <= wdata;
      err_q   <= illegal;
    end
  end

  // Data registers: load result and merged store word are both captured in ACCESS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata   <= 32'h0;
      merge_q <= 32'h0;
    end else if (state == ACCESS) begin
      if (we_q)
        merge_q <= merge_val;
      else
        rdata <= load_val;
    end
  end

  assign busy         = (state != IDLE);
  assign ready        = (state == RESP);
  assign err          = ready && err_q;
  assign memAdr       = {adr_q[31:2], 2'b00};
  assign memWrite     = ((state == ACCESS) && we_q && (size_q == 2'b10)) || (state == MERGE);
  assign memWriteData = (state == MERGE) ? merge_q : wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, held-req and mid-MERGE reset sequences, random traffic.
// Latency: expected response cycle is computed per access from the size/alignment rules.
// Backpressure: the bench holds req during busy in some sequences and expects it to be ignored.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] adr;
  logic [31:0] wdata;
  logic        busy;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] memAdr;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [31:0] memReadData;

  load_store_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .we           (we),
    .funct3       (funct3),
    .adr          (adr),
    .wdata        (wdata),
    .busy         (busy),
    .ready        (ready),
    .rdata        (rdata),
    .err          (err),
    .memAdr       (memAdr),
    .memWriteData (memWriteData),
    .memWrite     (memWrite),
    .memReadData  (memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on the rising edge; preload port used during reset.
  logic [31:0] mem [0:255];
  logic        pre_vld;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;

  assign memReadData = mem[memAdr[9:2]];

  always @(posedge clk) begin
    if (pre_vld)
      mem[pre_idx] <= pre_dat;
    else if (memWrite)
      mem[memAdr[9:2]] <= memWriteData;
  end

  // Reference state.
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rd;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pre_vld = 1'b1;
    pre_idx = idx;
    pre_dat = dat;
    @(negedge clk);
    pre_vld = 1'b0;
    ref_mem[idx] = dat;
  endtask

  // Reference model straight from the access rules.
  function automatic void model(input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] old, input logic [31:0] prev_rd,
                                output logic e, output logic [31:0] rd, output logic [31:0] nw,
                                output int lat, output int wr);
    int          off;
    int          sz;
    logic [31:0] sh;
    logic [31:0] mask;
    off = int'(a[1:0]);
    sz  = int'(f[1:0]);
    e   = (sz == 3) || (!w && f == 3'b110) || (sz == 2 && off != 0) || (sz == 1 && (off % 2) != 0);
    rd  = prev_rd;
    nw  = old;
    lat = 1;
    wr  = 0;
    if (!e) begin
      if (!w) begin
        lat = 2;
        sh  = old >> (8 * off);
        if (sz == 0) begin
          rd = sh & 32'hFF;
          if (!f[2] && rd >= 32'h80) rd = rd | 32'hFFFF_FF00;
        end else if (sz == 1) begin
          rd = sh & 32'hFFFF;
          if (!f[2] && rd >= 32'h8000) rd = rd | 32'hFFFF_0000;
        end else begin
          rd = old;
        end
      end else begin
        wr = 1;
        if (sz == 2) begin
          lat = 2;
          nw  = d;
        end else begin
          lat  = 3;
          mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << (8 * off);
          nw   = (old & ~mask) | ((d << (8 * off)) & mask);
        end
      end
    end
  endfunction

  // Issue one request and follow it to its ready pulse.
  task automatic run_op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input bit hold, output int lat, output logic e, output logic [31:0] rd,
                        output int wr);
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    req    = 1'b1;
    we     = w;
    funct3 = f;
    adr    = a;
    wdata  = d;
    @(negedge clk);
    lat = 1;
    wr  = 0;
    if (hold) begin
      wdata = ~d;
      adr   = a ^ 32'h4;
      we    = ~w;
    end else begin
      req = 1'b0;
    end
    chk("busy_after_req", {31'b0, busy}, 32'h1);
    chk("memadr", memAdr, {a[31:2], 2'b00});
    while (!ready && lat < 8) begin
      if (memWrite) wr++;
      @(negedge clk);
      lat++;
    end
    chk("ready_seen", {31'b0, ready}, 32'h1);
    if (memWrite) wr++;
    chk("resp_busy", {31'b0, busy}, 32'h1);
    e  = err;
    rd = rdata;
    req = 1'b0;
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("extra_ready", {31'b0, ready}, 32'h0);
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rd;
    logic        chk_rd;
    logic        exp_err;
    int          exp_lat;
    logic [31:0] exp_word;
  } vec_t;

  vec_t tbl [16];

  // Model-driven access plus full comparison and reference update.
  task automatic model_op(input string nm, input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
    logic        me;
    logic [31:0] mrd;
    logic [31:0] mnw;
    int          mlat;
    int          mwr;
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          wr;
    model(w, f, a, d, ref_mem[a[9:2]], ref_rd, me, mrd, mnw, mlat, mwr);
    run_op(w, f, a, d, hold, lat, e, rd, wr);
    chk({nm, "_lat"}, lat, mlat);
    chk({nm, "_err"}, {31'b0, e}, {31'b0, me});
    chk({nm, "_rdata"}, rd, mrd);
    chk({nm, "_wrcnt"}, wr, mwr);
    chk({nm, "_word"}, mem[a[9:2]], mnw);
    ref_mem[a[9:2]] = mnw;
    ref_rd = mrd;
  endtask

  initial begin
    int          lat;
    logic        e;
    logic [31:0] rd;
    int          wr;

    rst     = 1'b0;
    req     = 1'b0;
    we      = 1'b0;
    funct3  = 3'b000;
    adr     = 32'h0;
    wdata   = 32'h0;
    pre_vld = 1'b0;
    pre_idx = 8'h0;
    pre_dat = 32'h0;
    ref_rd  = 32'h0;

    tbl[0]  = '{1'b0, 3'b000, 32'h101, 32'h0,        32'h0000007F, 1'b1, 1'b0, 2, 32'h80FF7F01};
    tbl[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0, 2, 32'h80FF7F01};
    tbl[2]  = '{1'b0, 3'b100, 32'h102, 32'h0,        32'h000000FF, 1'b1, 1'b0, 2, 32'h80FF7F01};
    tbl[3]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'hFFFF80FF, 1'b1, 1'b0, 2, 32'h80FF7F01};
    tbl[4]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h000080FF, 1'b1, 1'b0, 2, 32'h80FF7F01};
    tbl[5]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h80FF7F01, 1'b1, 1'b0, 2, 32'h80FF7F01};
    tbl[6]  = '{1'b1, 3'b000, 32'h101, 32'h000000AA, 32'h0,        1'b0, 1'b0, 3, 32'h80FFAA01};
    tbl[7]  = '{1'b1, 3'b001, 32'h102, 32'h00001234, 32'h0,        1'b0, 1'b0, 3, 32'h1234AA01};
    tbl[8]  = '{1'b0, 3'b010, 32'h102, 32'h0,        32'h80FF7F01, 1'b1, 1'b1, 1, 32'h1234AA01};
    tbl[9]  = '{1'b1, 3'b001, 32'h103, 32'h00005678, 32'h80FF7F01, 1'b1, 1'b1, 1, 32'h1234AA01};
    tbl[10] = '{1'b0, 3'b010, 32'h100, 32'h0,        32'h1234AA01, 1'b1, 1'b0, 2, 32'h1234AA01};
    tbl[11] = '{1'b0, 3'b011, 32'h100, 32'h0,        32'h1234AA01, 1'b1, 1'b1, 1, 32'h1234AA01};
    tbl[12] = '{1'b1, 3'b011, 32'h100, 32'hFFFFFFFF, 32'h1234AA01, 1'b1, 1'b1, 1, 32'h1234AA01};
    tbl[13] = '{1'b1, 3'b010, 32'h100, 32'hCAFEF00D, 32'h0,        1'b0, 1'b0, 2, 32'hCAFEF00D};
    tbl[14] = '{1'b0, 3'b001, 32'h100, 32'h0,        32'hFFFFF00D, 1'b1, 1'b0, 2, 32'hCAFEF00D};
    tbl[15] = '{1'b0, 3'b111, 32'h100, 32'h0,        32'hFFFFF00D, 1'b1, 1'b1, 1, 32'hCAFEF00D};

    // Preload memory while held in reset.
    preload(8'h40, 32'h80FF7F01);
    for (int i = 0; i < 8; i++)
      preload(8'h80 + 8'(i), $urandom);

    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_memwrite", {31'b0, memWrite}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_memadr", memAdr, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 16; i++) begin
      run_op(tbl[i].w, tbl[i].f, tbl[i].a, tbl[i].d, 1'b0, lat, e, rd, wr);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_err", i), {31'b0, e}, {31'b0, tbl[i].exp_err});
      if (tbl[i].chk_rd)
        chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_wrcnt", i), wr, (tbl[i].w && !tbl[i].exp_err) ? 1 : 0);
      chk($sformatf("tbl%0d_word", i), mem[tbl[i].a[9:2]], tbl[i].exp_word);
      ref_mem[tbl[i].a[9:2]] = tbl[i].exp_word;
      if (!tbl[i].w) ref_rd = tbl[i].exp_rd;
    end

    // req held high through busy: must not start a second access.
    model_op("hold_lw", 1'b0, 3'b010, 32'h100, 32'h0, 1'b1);
    model_op("hold_sb", 1'b1, 3'b000, 32'h100, 32'h00000055, 1'b1);

    // Reset during MERGE of a byte store.
    @(negedge clk);
    req    = 1'b1;
    we     = 1'b1;
    funct3 = 3'b000;
    adr    = 32'h101;
    wdata  = 32'h00000077;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("merge_memwrite", {31'b0, memWrite}, 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_memwrite", {31'b0, memWrite}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_ready", {31'b0, ready}, 32'h0);
    chk("abort_err", {31'b0, err}, 32'h0);
    chk("abort_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    chk("abort_word", mem[8'h40], ref_mem[8'h40]);
    ref_rd = 32'h0;
    model_op("post_rst_lw", 1'b0, 3'b010, 32'h100, 32'h0, 1'b0);

    // Random traffic over a small window of words.
    for (int i = 0; i < 80; i++) begin
      model_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               32'h200 + 32'($urandom_range(0, 31)), $urandom, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
